vote_round_sequencer: RTL and testbench



---
 rtl/vote_pkg.sv | 25 ++
 rtl/vote_round_sequencer_if.sv | 32 +++
 rtl/vote_alarm_tracker.sv | 50 +++++
 rtl/vote_round_sequencer.sv | 143 ++++++++++++++
 tb/tb_vote_round_sequencer.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/vote_pkg.sv
// Shared types and default sizing for the voter-round sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vote_pkg;

    localparam int DEF_MAX_VOTERS   = 8;
    localparam int DEF_CNT_W        = 4;
    localparam int DEF_THR_W        = 3;
    localparam int DEF_ALARM_ROUNDS = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Limit a requested voter count to the number of physical voter inputs.
    function automatic logic [DEF_CNT_W-1:0] clamp_voters(input logic [DEF_CNT_W-1:0] n);
        if (n > DEF_CNT_W'(DEF_MAX_VOTERS)) begin
            return DEF_CNT_W'(DEF_MAX_VOTERS);
        end
        return n;
    endfunction

endpackage

// File: rtl/vote_round_sequencer_if.sv
// Bundle of round request, configuration and result signals.
// Latency: n/a (wires only).
// Backpressure: start is ignored by the slave while busy is high.
interface vote_round_sequencer_if
    import vote_pkg::*;
#(
    parameter int MAX_VOTERS = DEF_MAX_VOTERS,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int THR_W      = DEF_THR_W
);
    logic                  start;
    logic [MAX_VOTERS-1:0] voters;
    logic [CNT_W-1:0]      cfg_num_voters;
    logic [THR_W-1:0]      cfg_fails_okay;
    logic                  alarm_clr;
    logic                  busy;
    logic                  done;
    logic                  result;
    logic [CNT_W-1:0]      fail_count;
    logic                  cfg_err;
    logic                  alarm;

    modport master (
        output start, voters, cfg_num_voters, cfg_fails_okay, alarm_clr,
        input  busy, done, result, fail_count, cfg_err, alarm
    );

    modport slave (
        input  start, voters, cfg_num_voters, cfg_fails_okay, alarm_clr,
        output busy, done, result, fail_count, cfg_err, alarm
    );
endinterface

// File: rtl/vote_alarm_tracker.sv
// Counts consecutive failing rounds (saturating) and holds a sticky alarm.
// Latency: alarm updates on the edge where round_done is sampled.
// Backpressure: none; a set event always beats a coincident clear.
module vote_alarm_tracker #(
    parameter int ALARM_ROUNDS = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic round_done,
    input  logic round_fail,
    input  logic alarm_clr,
    output logic alarm
);
    localparam logic [3:0] LIMIT = 4'(ALARM_ROUNDS);

    logic [3:0] consec;
    logic [3:0] consec_upd;
    logic       set_alarm;

    // Post-round counter value and whether this round reaches the alarm threshold.
    always_comb begin
        consec_upd = consec;
        set_alarm  = 1'b0;
        if (round_done) begin
            if (round_fail) begin
                if (consec != LIMIT) begin
                    consec_upd = consec + 4'd1;
                end
                set_alarm = (consec_upd == LIMIT);
            end else begin
                consec_upd = 4'd0;
            end
        end
    end

    // Clear only takes effect when no alarm is being raised on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            consec <= 4'd0;
            alarm  <= 1'b0;
        end else begin
            consec <= (alarm_clr && !set_alarm) ? 4'd0 : consec_upd;
            if (set_alarm) begin
                alarm <= 1'b1;
            end else if (alarm_clr) begin
                alarm <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/vote_round_sequencer.sv
// Snapshots voters/config on start, scans one voter per clock, reports fail count and verdict.
// Latency: start sampled at edge k -> done pulse in the cycle after edge k+n+1 (n = clamped count).
// Backpressure: start is dropped (not queued) while busy.
module vote_round_sequencer
    import vote_pkg::*;
#(
    parameter int MAX_VOTERS   = DEF_MAX_VOTERS,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int THR_W        = DEF_THR_W,
    parameter int ALARM_ROUNDS = DEF_ALARM_ROUNDS
) (
    input  logic                    clk,
    input  logic                    rst,
    vote_round_sequencer_if.slave   bus
);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_VOTERS);

    state_t                state;
    state_t                state_nxt;

    logic [MAX_VOTERS-1:0] snap_voters;
    logic [THR_W-1:0]      snap_okay;
    logic [CNT_W-1:0]      n;
    logic [CNT_W-1:0]      idx;
    logic [CNT_W-1:0]      acc;

    logic                  load;
    logic                  step;
    logic                  finish;
    logic                  busy;

    logic [CNT_W-1:0]      n_req;
    logic                  over_cfg;
    logic                  cur_bit;
    logic                  round_fail;

    logic                  done_q;
    logic                  result_q;
    logic [CNT_W-1:0]      fail_count_q;
    logic                  cfg_err_q;
    logic                  alarm_w;

    assign n_req      = clamp_voters(bus.cfg_num_voters);
    assign over_cfg   = (bus.cfg_num_voters > LIMIT);
    assign cur_bit    = |(snap_voters & (MAX_VOTERS'(1) << idx));
    assign round_fail = (acc > CNT_W'(snap_okay));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a zero-voter round skips straight to DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = (n_req == '0) ? DONE : SCAN;
                end
            end
            SCAN: begin
                if (idx == n - ONE) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Per-state control strobes for the datapath.
    always_comb begin
        load   = (state == IDLE) && bus.start;
        step   = (state == SCAN);
        finish = (state == DONE);
        busy   = (state != IDLE);
    end

    // Snapshot, serial accumulate, and result registers (published as DONE is left).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_voters  <= '0;
            snap_okay    <= '0;
            n            <= '0;
            idx          <= '0;
            acc          <= '0;
            done_q       <= 1'b0;
            result_q     <= 1'b0;
            fail_count_q <= '0;
        end else begin
            done_q <= finish;
            if (load) begin
                snap_voters <= bus.voters;
                snap_okay   <= bus.cfg_fails_okay;
                n           <= n_req;
                idx         <= '0;
                acc         <= '0;
            end else if (step) begin
                acc <= acc + CNT_W'(cur_bit);
                idx <= idx + ONE;
            end
            if (finish) begin
                fail_count_q <= acc;
                result_q     <= round_fail;
            end
        end
    end

    // Sticky configuration error; a new over-range request beats a coincident clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_err_q <= 1'b0;
        end else if (load && over_cfg) begin
            cfg_err_q <= 1'b1;
        end else if (bus.alarm_clr) begin
            cfg_err_q <= 1'b0;
        end
    end

    vote_alarm_tracker #(
        .ALARM_ROUNDS (ALARM_ROUNDS)
    ) u_alarm (
        .clk        (clk),
        .rst        (rst),
        .round_done (finish),
        .round_fail (round_fail),
        .alarm_clr  (bus.alarm_clr),
        .alarm      (alarm_w)
    );

    assign bus.busy       = busy;
    assign bus.done       = done_q;
    assign bus.result     = result_q;
    assign bus.fail_count = fail_count_q;
    assign bus.cfg_err    = cfg_err_q;
    assign bus.alarm      = alarm_w;
endmodule

// File: tb/tb_vote_round_sequencer.sv
// Directed rounds with a scoreboard of expected done results.
// Latency: checks done arrives on the exact expected cycle.
// Backpressure: exercises start-while-busy and reset mid-round.
module tb_vote_round_sequencer;
    import vote_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vote_round_sequencer_if #(.MAX_VOTERS(8), .CNT_W(4), .THR_W(3)) bus ();

    vote_round_sequencer #(
        .MAX_VOTERS   (8),
        .CNT_W        (4),
        .THR_W        (3),
        .ALARM_ROUNDS (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int       id;
        logic [3:0] fc;
        logic     res;
        logic     alm;
        int       cyc;
    } exp_t;

    exp_t sbq[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.done) begin
            if (sbq.size() == 0) begin
                chk("spurious_done", int'(bus.done), 0);
            end else begin
                e = sbq.pop_front();
                chk($sformatf("r%0d_fail_count", e.id), int'(bus.fail_count), int'(e.fc));
                chk($sformatf("r%0d_result", e.id), int'(bus.result), int'(e.res));
                chk($sformatf("r%0d_alarm", e.id), int'(bus.alarm), int'(e.alm));
                chk($sformatf("r%0d_latency", e.id), cyc, e.cyc);
            end
        end
    end

    // Issue one start pulse and queue the expected outcome; returns with cyc == k.
    task automatic start_round(input int id, input logic [7:0] v, input logic [3:0] nreq,
                               input logic [2:0] ok, input logic [3:0] efc,
                               input logic eres, input logic ealm, output int k);
        exp_t e;
        int   neff;
        @(negedge clk);
        bus.voters         = v;
        bus.cfg_num_voters = nreq;
        bus.cfg_fails_okay = ok;
        bus.start          = 1'b1;
        k    = cyc + 1;
        neff = (nreq > 8) ? 8 : int'(nreq);
        e.id = id; e.fc = efc; e.res = eres; e.alm = ealm; e.cyc = k + neff + 1;
        sbq.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        chk($sformatf("r%0d_busy", id), int'(bus.busy), 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && sbq.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("pending_rounds", sbq.size(), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"},       int'(bus.busy),       0);
        chk({tag, "_done"},       int'(bus.done),       0);
        chk({tag, "_result"},     int'(bus.result),     0);
        chk({tag, "_fail_count"}, int'(bus.fail_count), 0);
        chk({tag, "_cfg_err"},    int'(bus.cfg_err),    0);
        chk({tag, "_alarm"},      int'(bus.alarm),      0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst                = 1'b1;
        bus.start          = 1'b0;
        bus.voters         = '0;
        bus.cfg_num_voters = '0;
        bus.cfg_fails_okay = '0;
        bus.alarm_clr      = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_outputs_zero("idle");

        // 0001_0110 over 5 voters: bits 1,2,4 fail -> 3 > 1.
        start_round(1, 8'b0001_0110, 4'd5, 3'd1, 4'd3, 1'b1, 1'b0, k);
        wait_idle();
        chk("hold_fail_count", int'(bus.fail_count), 3);
        chk("hold_result", int'(bus.result), 1);
        // Two voters: bits 0,1 = 0,1 -> 1, not > 1.
        start_round(2, 8'b0001_0110, 4'd2, 3'd1, 4'd1, 1'b0, 1'b0, k);
        wait_idle();
        // Zero voters: done right after the DONE cycle, empty count.
        start_round(3, 8'hFF, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0, k);
        wait_idle();
        // Snapshot isolation and ignored start while busy: 0000_0101 over 4 -> 2.
        start_round(4, 8'b0000_0101, 4'd4, 3'd0, 4'd2, 1'b1, 1'b0, k);
        bus.voters = 8'hFF;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        // Second consecutive fail, then a pass resets progress (okay=7 boundary).
        start_round(5, 8'h0F, 4'd3, 3'd2, 4'd3, 1'b1, 1'b0, k);
        wait_idle();
        start_round(6, 8'h0F, 4'd4, 3'd7, 4'd4, 1'b0, 1'b0, k);
        wait_idle();
        // Three back-to-back fails; alarm_clr on the third result edge loses to the set.
        start_round(7, 8'hFF, 4'd8, 3'd0, 4'd8, 1'b1, 1'b0, k);
        wait_idle();
        start_round(8, 8'hFF, 4'd8, 3'd0, 4'd8, 1'b1, 1'b0, k);
        wait_idle();
        start_round(9, 8'hFF, 4'd8, 3'd0, 4'd8, 1'b1, 1'b1, k);
        while (cyc < k + 8) @(negedge clk);
        bus.alarm_clr = 1'b1;
        @(negedge clk);
        bus.alarm_clr = 1'b0;
        wait_idle();
        // Passing round leaves the sticky alarm up.
        start_round(10, 8'h00, 4'd8, 3'd0, 4'd0, 1'b0, 1'b1, k);
        wait_idle();
        @(negedge clk);
        bus.alarm_clr = 1'b1;
        @(negedge clk);
        bus.alarm_clr = 1'b0;
        chk("alarm_after_clr", int'(bus.alarm), 0);
        // Over-range count clamps to 8 voters: 8 > 7, and cfg_err sets.
        start_round(11, 8'hFF, 4'd12, 3'd7, 4'd8, 1'b1, 1'b0, k);
        chk("cfg_err_set", int'(bus.cfg_err), 1);
        wait_idle();
        chk("hold_fail_count_clamped", int'(bus.fail_count), 8);
        start_round(12, 8'h00, 4'd3, 3'd0, 4'd0, 1'b0, 1'b0, k);
        wait_idle();
        chk("cfg_err_sticky", int'(bus.cfg_err), 1);
        // Reset mid-scan: immediate abort, outputs zero, no done afterwards.
        @(negedge clk);
        bus.voters         = 8'hFF;
        bus.cfg_num_voters = 4'd8;
        bus.start          = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_outputs_zero("mid_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("post_reset_busy", int'(bus.busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
